// File: rtl/bcd_sseg_if.sv
// Handshake and pattern bundle between a requester and bcd_sseg_conv.
// The master side requests conversions; the slave side (the converter) returns segment patterns.
interface bcd_sseg_if #(
  parameter int W = 14
);
  logic         start;
  logic [W-1:0] bin;
  logic [3:0]   dp_in;
  logic         ready;
  logic         done_tick;
  logic [7:0]   sseg3;
  logic [7:0]   sseg2;
  logic [7:0]   sseg1;
  logic [7:0]   sseg0;

  modport master (
    output start, bin, dp_in,
    input  ready, done_tick, sseg3, sseg2, sseg1, sseg0
  );

  modport slave (
    input  start, bin, dp_in,
    output ready, done_tick, sseg3, sseg2, sseg1, sseg0
  );
endinterface

// File: rtl/bcd_sseg_conv.sv
// Binary to four active-low 7-segment patterns via a shift-add-3 FSM, one bit per cycle.
// Optional LEADING_ZERO_BLANK_EN blanks leading zero digits 3..1.
module bcd_sseg_conv #(
  parameter int W = 14
) (
  input  logic       clk,
  input  logic       reset,
  bcd_sseg_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;

  state_t          state_q;
  logic [W-1:0]    bin_q;
  logic [15:0]     bcd_q;
  logic [3:0]      cnt_q;
  logic [3:0]      dp_q;
  logic            ready_q;
  logic            done_q;
  logic [31:0]     sseg_q;

  logic [15:0]     adj_d;
  logic [16+W-1:0] shift_d;
  logic [15:0]     bcd_d;
  logic [W-1:0]    bin_d;

  function automatic logic [6:0] seg_pat(input logic [3:0] d);
    case (d)
      4'd0:    seg_pat = 7'h40;
      4'd1:    seg_pat = 7'h79;
      4'd2:    seg_pat = 7'h24;
      4'd3:    seg_pat = 7'h30;
      4'd4:    seg_pat = 7'h19;
      4'd5:    seg_pat = 7'h12;
      4'd6:    seg_pat = 7'h02;
      4'd7:    seg_pat = 7'h78;
      4'd8:    seg_pat = 7'h00;
      4'd9:    seg_pat = 7'h10;
      default: seg_pat = 7'h7F;
    endcase
  endfunction

  function automatic logic [31:0] encode(input logic [15:0] bcd, input logic [3:0] dp);
    logic [3:0] blank;
    blank = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    blank[3] = (bcd[15:12] == 4'd0);
    blank[2] = blank[3] && (bcd[11:8] == 4'd0);
    blank[1] = blank[2] && (bcd[7:4] == 4'd0);
`endif
    encode = 32'h0;
    for (int k = 0; k < 4; k++) begin
      encode[8*k +: 8] = blank[k] ? 8'hFF : {~dp[k], seg_pat(bcd[4*k +: 4])};
    end
  endfunction

  // Add-3 correction on every digit, then one-bit shift of the combined BCD/binary register.
  always_comb begin
    adj_d = bcd_q;
    for (int k = 0; k < 4; k++) begin
      if (bcd_q[4*k +: 4] > 4'd4) adj_d[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    shift_d = {adj_d, bin_q} << 1;
    bcd_d   = shift_d[16+W-1:W];
    bin_d   = shift_d[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      dp_q    <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      sseg_q  <= 32'hFFFF_FFFF;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            bin_q   <= bus.bin;
            dp_q    <= bus.dp_in;
            ready_q <= 1'b0;
            if (14'(bus.bin) > 14'd9999) begin
              sseg_q  <= 32'hBFBF_BFBF;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              bcd_q   <= '0;
              cnt_q   <= 4'(W - 1);
              state_q <= OP;
            end
          end
        end
        OP: begin
          bcd_q <= bcd_d;
          bin_q <= bin_d;
          if (cnt_q == 4'd0) begin
            sseg_q  <= encode(bcd_d, dp_q);
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.done_tick = done_q;
  assign bus.sseg3     = sseg_q[31:24];
  assign bus.sseg2     = sseg_q[23:16];
  assign bus.sseg1     = sseg_q[15:8];
  assign bus.sseg0     = sseg_q[7:0];

endmodule

// File: tb/tb_bcd_sseg_conv.sv
// Table-driven plus randomized checks of bcd_sseg_conv against a decimal-arithmetic model.
module tb_bcd_sseg_conv;
  localparam int W = 14;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  int   done_cnt = 0;
  int   cyc = 0;

  bcd_sseg_if #(.W(W)) bus ();

  bcd_sseg_conv #(.W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.done_tick) done_cnt <= done_cnt + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [7:0] LUT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                      8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  function automatic logic [31:0] model(input int v, input logic [3:0] dp);
    logic [31:0] res;
    logic [7:0]  pat;
    int          digs [4];
`ifdef LEADING_ZERO_BLANK_EN
    bit          lead;
    lead = 1'b1;
`endif
    if (v > 9999) return 32'hBFBF_BFBF;
    res = 32'h0;
    for (int k = 0; k < 4; k++) digs[k] = (v / (10 ** k)) % 10;
    for (int k = 3; k >= 0; k--) begin
      pat    = LUT[digs[k]];
      pat[7] = ~dp[k];
`ifdef LEADING_ZERO_BLANK_EN
      if (lead && k > 0 && digs[k] == 0) pat = 8'hFF;
      if (digs[k] != 0) lead = 1'b0;
`endif
      res[8*k +: 8] = pat;
    end
    return res;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] segs();
    return {bus.sseg3, bus.sseg2, bus.sseg1, bus.sseg0};
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) chk("ready_timeout", 32'(bus.ready), 32'd1);
  endtask

  task automatic wait_done(output int c);
    int n = 0;
    c = -1;
    while (n < 60) begin
      @(negedge clk);
      if (bus.done_tick) begin
        c = cyc;
        return;
      end
      n++;
    end
    chk("done_timeout", 32'(bus.done_tick), 32'd1);
  endtask

  task automatic run_conv(input string name, input int b, input logic [3:0] dp,
                          input logic [31:0] exp);
    int k;
    wait_ready();
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = W'(b);
    bus.dp_in = dp;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.bin   = W'($urandom);
    bus.dp_in = 4'($urandom);
    k = 0;
    while (!bus.done_tick && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({name, "_latency"}, 32'(k + 1), (b > 9999) ? 32'd1 : 32'(W + 1));
    chk({name, "_sseg"}, segs(), exp);
    @(posedge clk);
    #1;
    chk({name, "_after"}, {30'd0, bus.ready, bus.done_tick}, 32'd2);
  endtask

  typedef struct {
    int          b;
    logic [3:0]  dp;
    logic [31:0] exp_nb;
    logic [31:0] exp_bl;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int t0, d0, d1, c0;
    logic [31:0] e;
    int rb;
    logic [3:0] rd;

    tbl[0]  = '{1234,  4'b0000, 32'hF9A4B099, 32'hF9A4B099};
    tbl[1]  = '{9999,  4'b0100, 32'h90109090, 32'h90109090};
    tbl[2]  = '{0,     4'b0000, 32'hC0C0C0C0, 32'hFFFFFFC0};
    tbl[3]  = '{7,     4'b0000, 32'hC0C0C0F8, 32'hFFFFFFF8};
    tbl[4]  = '{10000, 4'b0000, 32'hBFBFBFBF, 32'hBFBFBFBF};
    tbl[5]  = '{56,    4'b0000, 32'hC0C09282, 32'hFFFF9282};
    tbl[6]  = '{5,     4'b0001, 32'hC0C0C012, 32'hFFFFFF12};
    tbl[7]  = '{16383, 4'b1111, 32'hBFBFBFBF, 32'hBFBFBFBF};
    tbl[8]  = '{8000,  4'b1111, 32'h00404040, 32'h00404040};
    tbl[9]  = '{305,   4'b0100, 32'hC030C092, 32'hFF30C092};
    tbl[10] = '{0,     4'b1111, 32'h40404040, 32'hFFFFFF40};

    reset = 1'b1;
    bus.start = 1'b0;
    bus.bin   = '0;
    bus.dp_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_sseg", segs(), 32'hFFFFFFFF);
    chk("reset_ctrl", {30'd0, bus.ready, bus.done_tick}, 32'd2);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
      e = tbl[i].exp_bl;
`else
      e = tbl[i].exp_nb;
`endif
      run_conv($sformatf("tbl%0d", i), tbl[i].b, tbl[i].dp, e);
    end

    // Second start during OP must be ignored.
    wait_ready();
    c0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.bin = W'(4321); bus.dp_in = 4'b0000;
    @(posedge clk); #1;
    t0 = cyc;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1; bus.bin = W'(10000); bus.dp_in = 4'b1111;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(d0);
    chk("ignore_latency", 32'(d0 - t0 + 1), 32'(W + 1));
    wait_ready();
    repeat (3) @(negedge clk);
    chk("ignore_count", 32'(done_cnt - c0), 32'd1);
    chk("ignore_sseg", segs(), model(4321, 4'b0000));

    // Reset mid-conversion aborts.
    c0 = done_cnt;
    @(negedge clk);
    bus.start = 1'b1; bus.bin = W'(4321); bus.dp_in = 4'b0000;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort_sseg", segs(), 32'hFFFFFFFF);
    chk("abort_ready", 32'(bus.ready), 32'd1);
    repeat (W + 4) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - c0), 32'd0);
    run_conv("post_abort", 56, 4'b0000, model(56, 4'b0000));

    // start held high: back-to-back conversions.
    wait_ready();
    @(negedge clk);
    bus.start = 1'b1; bus.bin = W'(1234); bus.dp_in = 4'b0000;
    wait_done(d0);
    wait_done(d1);
    bus.start = 1'b0;
    chk("b2b_period", 32'(d1 - d0), 32'(W + 2));
    chk("b2b_sseg", segs(), model(1234, 4'b0000));

    for (int i = 0; i < 200; i++) begin
      rb = (i % 8 == 0) ? int'($urandom_range(16383, 9990)) : int'($urandom_range(16383, 0));
      if (i % 5 == 0) rb = rb % 200;
      rd = 4'($urandom);
      run_conv($sformatf("rand%0d", i), rb, rd, model(rb, rd));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
